if_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipelined CPU. It owns the program counter, fetches words from instruction memory over a valid/ready handshake, and drives the IF/ID pipeline register whose opcode/funct fields feed the instruction decoder in ID. It honours stall requests from the hazard unit and redirects (branch/jump/jr) from the resolving stage, flushing wrong-path instructions.

---
 rtl/if_stage.sv | 124 ++++++++++++
 tb/tb_if_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a valid/ready handshake and drives IF/ID.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid;
  logic [31:0] drain_addr;
  logic        hit;
  logic [31:0] redirect_target;
  logic        load_valid;

  assign imem_req        = !reset && (state == FETCH || state == DRAIN);
  assign imem_addr       = (state == DRAIN) ? drain_addr : pc;
  assign hit             = imem_req && imem_ready;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign ifid_pc_plus4   = ifid_pc + 32'd4;
  assign opcode          = ifid_instr[31:26];
  assign funct           = ifid_instr[5:0];

  // True whenever IF/ID is about to receive a real instruction.
  assign load_valid = !reset && !redirect && !stall &&
                      ((state == FETCH && hit) || state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      skid       <= 32'h0;
      drain_addr <= 32'h0;
      ifid_valid <= 1'b0;
      ifid_instr <= 32'h0;
      ifid_pc    <= 32'h0;
    end else if (redirect) begin
      ifid_valid <= 1'b0;
      ifid_instr <= 32'h0;
      ifid_pc    <= 32'h0;
      skid       <= 32'h0;
      pc         <= redirect_target;
      // An un-accepted request must still complete before the target is fetched.
      if (state == FETCH && !imem_ready) begin
        drain_addr <= pc;
        state      <= DRAIN;
      end else if (state == DRAIN && !hit) begin
        state <= DRAIN;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (hit) begin
            pc <= pc + 32'd4;
            if (stall) begin
              skid  <= imem_rdata;
              state <= HOLD;
            end else begin
              ifid_valid <= 1'b1;
              ifid_instr <= imem_rdata;
              ifid_pc    <= pc;
            end
          end else if (!stall) begin
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
            ifid_pc    <= 32'h0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_instr <= skid;
            ifid_pc    <= pc - 32'd4;
            state      <= FETCH;
          end
        end
        DRAIN: begin
          if (hit) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch <= 32'h0;
      perf_stall <= 32'h0;
      perf_flush <= 32'h0;
    end else begin
      if (load_valid) perf_fetch <= perf_fetch + 32'd1;
      if (stall)      perf_stall <= perf_stall + 32'd1;
      if (redirect)   perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then random stall/redirect/ready traffic
// against a transaction-level model of the fetch stream.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_ready;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;
  logic [5:0]  opcode, funct;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

  int checks = 0;
  int errors = 0;

  // Model of the fetch stream: next address to fetch, a parked word, an abandoned request.
  logic [31:0] m_next, m_held_word, m_held_pc, m_drain_addr;
  logic        m_hold, m_drain;
  logic        m_valid;
  logic [31:0] m_instr, m_ipc;
  int          m_fetch, m_stall, m_flush;

  if_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4), .opcode(opcode), .funct(funct)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  // Memory returns its own address as the instruction word.
  assign imem_rdata = imem_addr;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic rd,
                               input logic rdy, input logic [31:0] rpc);
    logic        exp_req, hit;
    logic [31:0] exp_addr;
    reset = rst; stall = st; redirect = rd; imem_ready = rdy; redirect_pc = rpc;
    @(negedge clk);
    exp_req  = !rst && !m_hold;
    exp_addr = m_drain ? m_drain_addr : m_next;
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) checkOutput("imem_addr", imem_addr, exp_addr);
    hit = exp_req && rdy;
    if (rst) begin
      m_next = 32'h0000_3000; m_hold = 0; m_drain = 0; m_drain_addr = 0;
      m_valid = 0; m_instr = 0; m_ipc = 0;
      m_fetch = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (st) m_stall++;
      if (rd) begin
        m_flush++;
        if (m_drain) m_drain = !hit;
        else if (!m_hold && !rdy) begin m_drain = 1; m_drain_addr = m_next; end
        m_hold = 0; m_valid = 0; m_instr = 0; m_ipc = 0;
        m_next = rpc & 32'hFFFF_FFFC;
      end else if (m_hold) begin
        if (!st) begin
          m_hold = 0; m_valid = 1; m_instr = m_held_word; m_ipc = m_held_pc; m_fetch++;
        end
      end else if (m_drain) begin
        if (hit) m_drain = 0;
      end else if (hit) begin
        m_next = m_next + 4;
        if (st) begin m_hold = 1; m_held_word = exp_addr; m_held_pc = exp_addr; end
        else begin m_valid = 1; m_instr = exp_addr; m_ipc = exp_addr; m_fetch++; end
      end else if (!st) begin
        m_valid = 0; m_instr = 0; m_ipc = 0;
      end
    end
    @(posedge clk);
    #1;
    checkOutput("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    checkOutput("ifid_instr", ifid_instr, m_instr);
    checkOutput("ifid_pc", ifid_pc, m_ipc);
    checkOutput("ifid_pc_plus4", ifid_pc_plus4, m_ipc + 32'd4);
    checkOutput("opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
    checkOutput("funct", {26'b0, funct}, {26'b0, m_instr[5:0]});
  endtask

  initial begin
    m_hold = 0; m_drain = 0; m_next = 0; m_drain_addr = 0;
    m_held_word = 0; m_held_pc = 0;
    m_fetch = 0; m_stall = 0; m_flush = 0;
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);

    // Streaming from the reset vector.
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("first_instr", ifid_instr, 32'h0000_3000);
    applyStimulus(0, 0, 0, 1, 0);
    // Stall across the hit of 0x3008.
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("stall_hold_instr", ifid_instr, 32'h0000_3004);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("unstall_instr", ifid_instr, 32'h0000_3008);
    checkOutput("unstall_plus4", ifid_pc_plus4, 32'h0000_300C);
    checkOutput("unstall_next_addr", imem_addr, 32'h0000_300C);
    applyStimulus(0, 0, 0, 1, 0);
    // Redirect while 0x3010 is waiting on memory.
    applyStimulus(0, 0, 1, 0, 32'h0000_5000);
    checkOutput("drain_addr_hold", imem_addr, 32'h0000_3010);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("drain_discard", {31'b0, ifid_valid}, 32'h0);
    checkOutput("after_drain_addr", imem_addr, 32'h0000_5000);
    applyStimulus(0, 0, 0, 1, 0);
    // Redirect to a misaligned target while streaming.
    applyStimulus(0, 0, 1, 1, 32'h0000_4002);
    checkOutput("redir_bubble", ifid_instr, 32'h0);
    checkOutput("redir_addr", imem_addr, 32'h0000_4000);
    applyStimulus(0, 0, 0, 1, 0);
    // Stall and redirect together.
    applyStimulus(0, 1, 1, 1, 32'h0000_6000);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("stall_redir_instr", ifid_instr, 32'h0000_6000);
    // Address wrap at the top of memory.
    applyStimulus(0, 0, 1, 1, 32'hFFFF_FFFE);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_plus4", ifid_pc_plus4, 32'h0);
    checkOutput("wrap_next_addr", imem_addr, 32'h0);
    applyStimulus(0, 0, 0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, $urandom);
    end

`ifdef IF_PERF_CNT_EN
    checkOutput("perf_fetch", perf_fetch, m_fetch);
    checkOutput("perf_stall", perf_stall, m_stall);
    checkOutput("perf_flush", perf_flush, m_flush);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
